// File: rtl/bin2bcd_6digit_pkg.sv
// Shared constants for the 6-digit BCD converter and the seven-segment display wrapper:
// digit counts, FSM encodings, saturation value and the leading-zero blanking helper.
package bin2bcd_6digit_pkg;

  localparam int DIGITS      = 6;
  localparam int BCD_W       = 4 * DIGITS;
  localparam int WORK_DIGITS = DIGITS + 1;
  localparam int WORK_W      = 4 * WORK_DIGITS;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

  localparam logic [BCD_W-1:0] BCD_SAT = 24'h999999;

  // Digits up to and including the most significant nonzero one are lit; units always lit.
  function automatic logic [DIGITS-1:0] lz_enable(input logic [BCD_W-1:0] bcd);
    logic [DIGITS-1:0] en;
    en = {{(DIGITS-1){1'b0}}, 1'b1};
    for (int i = 1; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] != 4'd0) en = {DIGITS{1'b1}} >> (DIGITS - 1 - i);
    end
    return en;
  endfunction

endpackage

// File: rtl/bin2bcd_6digit_if.sv
// Request/result bundle between a client and the binary-to-BCD converter.
interface bin2bcd_6digit_if
  import bin2bcd_6digit_pkg::*;
#(
  parameter int BIN_WIDTH = 20
);
  logic                  start;
  logic [BIN_WIDTH-1:0]  bin;
  logic                  busy;
  logic                  done;
  logic                  overflow;
  logic [BCD_W-1:0]      number_BCD;
  logic [DIGITS-1:0]     enable;

  modport master (
    output start, bin,
    input  busy, done, overflow, number_BCD, enable
  );

  modport slave (
    input  start, bin,
    output busy, done, overflow, number_BCD, enable
  );
endinterface

// File: rtl/bin2bcd_6digit_bcd_digit_adj.sv
// One double-dabble correction cell: a BCD digit of 5 or more gets +3 before the left shift.
module bcd_digit_adj (
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

// File: rtl/bin2bcd_6digit.sv
// Sequential shift-and-add-3 converter: one input bit per clock, registered result with
// saturation above 999999 and optional leading-zero blanking of the display digits.
module bin2bcd_6digit
  import bin2bcd_6digit_pkg::*;
#(
  parameter int BIN_WIDTH = 20,
  parameter bit BLANK_LZ  = 1'b1
) (
  input  logic              clk,
  input  logic              rst_N,
  bin2bcd_6digit_if.slave   bus
);

  localparam int                CNT_W    = $clog2(BIN_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BIN_WIDTH - 1);

  logic [1:0]            state;
  logic [CNT_W-1:0]      bit_cnt;
  logic [BIN_WIDTH-1:0]  shift_q;
  logic [WORK_W-1:0]     work_q;
  logic [WORK_W-1:0]     work_adj;

  logic                  busy_q;
  logic                  done_q;
  logic                  ovf_q;
  logic [BCD_W-1:0]      bcd_q;
  logic [DIGITS-1:0]     en_q;

  logic                  ovf_next;
  logic [BCD_W-1:0]      bcd_next;
  logic [DIGITS-1:0]     en_next;

  for (genvar g = 0; g < WORK_DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d (work_q[4*g +: 4]),
      .q (work_adj[4*g +: 4])
    );
  end

  // The 7th work digit only becomes nonzero for values of a million or more.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    ovf_next = 1'b0;
    bcd_next = work_q[BCD_W-1:0];
    en_next  = {DIGITS{1'b1}};
    if (work_q[WORK_W-1 -: 4] != 4'd0) begin
      ovf_next = 1'b1;
      bcd_next = BCD_SAT;
    end else if (BLANK_LZ) begin
      en_next = lz_enable(bcd_next);
    end
  end

  // NOTE: the working registers are reset too, so an aborted conversion leaves no residue.
  always_ff @(posedge clk or negedge rst_N) begin
    if (!rst_N) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      shift_q <= '0;
      work_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      bcd_q   <= '0;
      en_q    <= {{(DIGITS-1){1'b0}}, 1'b1};
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register sees pre-edge values.
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            shift_q <= bus.bin;
            work_q  <= '0;
            bit_cnt <= '0;
            busy_q  <= 1'b1;
            state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          {work_q, shift_q} <= {work_adj[WORK_W-2:0], shift_q, 1'b0};
          bit_cnt           <= bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) state <= ST_FINISH;
        end
        ST_FINISH: begin
          bcd_q  <= bcd_next;
          en_q   <= en_next;
          ovf_q  <= ovf_next;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.overflow   = ovf_q;
  assign bus.number_BCD = bcd_q;
  assign bus.enable     = en_q;

endmodule
